// File: rtl/uart_cfg_ctrl.sv
// uart_cfg_ctrl: frame-level controller behind the UART receiver.
// Assembles HEADER/ADDR/D3..D0/CSUM frames from per-byte strobes and issues
// one handshaked register write per valid frame. Reports checksum errors,
// inter-byte timeout and overrun on frame_err/err_code.
// Optional feature macro: UART_CFG_ACK_EN (ACK/NAK reply byte to the UART
// transmitter). Without it tx_start/tx_data are tied to 0 and tx_busy is unused.
// Note: sys_rst_n is active-high despite its name (1 = reset), asynchronous.
module uart_cfg_ctrl #(
  parameter int unsigned SYS_CLK_FRE  = 50_000_000,
  parameter int unsigned BPS          = 9600,
  parameter int unsigned TIMEOUT_BITS = 40,
  parameter int unsigned TIMEOUT_CYC  = SYS_CLK_FRE / BPS * TIMEOUT_BITS,
  parameter logic [7:0]  HEADER       = 8'hAA
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_done,
  input  logic [7:0]  rx_data,
  output logic        cfg_valid,
  input  logic        cfg_ready,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM, S_WRITE} state_t;

  // The error pulse appears in the cycle after the timer reaches this value.
  localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYC - 1);

  state_t      r_state, w_state_nxt;
  logic [23:0] r_timer, w_timer_nxt, w_timer_inc;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_sum, w_sum_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic [31:0] r_data, w_data_nxt;
  logic        r_cfg_valid, w_cfg_valid_nxt;
  logic [7:0]  r_cfg_addr, w_cfg_addr_nxt;
  logic [31:0] r_cfg_data, w_cfg_data_nxt;
  logic        r_frame_ok, w_frame_ok_nxt;
  logic        r_frame_err, w_frame_err_nxt;
  logic [1:0]  r_err_code, w_err_code_nxt;
  logic [15:0] r_frame_cnt, w_frame_cnt_nxt;

  assign w_timer_inc = r_timer + 24'd1;

  // State and datapath registers; reset discards any partial frame or write.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= '0;
      r_cfg_data  <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sum       <= w_sum_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_cfg_valid <= w_cfg_valid_nxt;
      r_cfg_addr  <= w_cfg_addr_nxt;
      r_cfg_data  <= w_cfg_data_nxt;
      r_frame_ok  <= w_frame_ok_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_err_code  <= w_err_code_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
    end
  end

  // Next-state, frame assembly, timeout and write handshake.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_cnt_nxt       = r_cnt;
    w_sum_nxt       = r_sum;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_cfg_valid_nxt = r_cfg_valid;
    w_cfg_addr_nxt  = r_cfg_addr;
    w_cfg_data_nxt  = r_cfg_data;
    w_frame_ok_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_frame_cnt_nxt = r_frame_cnt;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (rx_done && (rx_data == HEADER)) w_state_nxt = S_ADDR;
      end
      S_ADDR, S_DATA, S_CSUM: begin
        if (rx_done) begin
          // A strobe in the expiry cycle wins over the timeout.
          w_timer_nxt = '0;
          if (r_state == S_ADDR) begin
            w_addr_nxt  = rx_data;
            w_sum_nxt   = rx_data;
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end else if (r_state == S_DATA) begin
            w_data_nxt = {r_data[23:0], rx_data};
            w_sum_nxt  = r_sum + rx_data;
            w_cnt_nxt  = r_cnt + 2'd1;
            if (r_cnt == 2'd3) w_state_nxt = S_CSUM;
          end else if (rx_data == r_sum) begin
            w_cfg_valid_nxt = 1'b1;
            w_cfg_addr_nxt  = r_addr;
            w_cfg_data_nxt  = r_data;
            w_state_nxt     = S_WRITE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = 2'b01;
            w_state_nxt     = S_IDLE;
          end
        end else if (w_timer_inc == TO_LAST) begin
          w_timer_nxt     = '0;
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = 2'b10;
          w_state_nxt     = S_IDLE;
        end else begin
          w_timer_nxt = w_timer_inc;
        end
      end
      S_WRITE: begin
        w_timer_nxt = '0;
        if (rx_done) begin
          w_frame_err_nxt = 1'b1;
          w_err_code_nxt  = 2'b11;
        end
        if (r_cfg_valid && cfg_ready) begin
          w_cfg_valid_nxt = 1'b0;
          w_frame_ok_nxt  = 1'b1;
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign cfg_valid = r_cfg_valid;
  assign cfg_addr  = r_cfg_addr;
  assign cfg_data  = r_cfg_data;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;

`ifdef UART_CFG_ACK_EN
  logic       r_tx_start, r_pend;
  logic [7:0] r_tx_data, r_pend_data;
  logic       w_req;
  logic [7:0] w_req_byte;

  // Reply request: ACK after an accepted write, NAK after checksum/timeout.
  always_comb begin
    w_req      = r_frame_ok || (r_frame_err && (r_err_code != 2'b11));
    w_req_byte = r_frame_ok ? 8'h06 : 8'h15;
  end

  // Single-slot reply buffer; a newer reply replaces an older pending one.
  always_ff @(posedge sys_clk or posedge sys_rst_n) begin
    if (sys_rst_n) begin
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
    end else begin
      r_tx_start <= 1'b0;
      if (!tx_busy && (w_req || r_pend)) begin
        r_tx_start <= 1'b1;
        r_tx_data  <= w_req ? w_req_byte : r_pend_data;
        r_pend     <= 1'b0;
      end else if (w_req) begin
        r_pend      <= 1'b1;
        r_pend_data <= w_req_byte;
      end
    end
  end

  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
`else
  logic w_unused_tx_busy;
  assign w_unused_tx_busy = tx_busy;
  assign tx_start = 1'b0;
  assign tx_data  = '0;
`endif

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// Directed self-checking bench for uart_cfg_ctrl (TIMEOUT_CYC overridden to 100).
module tb_uart_cfg_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        rx_done = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        cfg_ready = 1'b1;
  logic        tx_busy = 1'b0;
  logic        cfg_valid, frame_ok, frame_err, tx_start;
  logic [7:0]  cfg_addr, tx_data;
  logic [31:0] cfg_data;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  uart_cfg_ctrl #(.TIMEOUT_CYC(100), .HEADER(8'hAA)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; returns in the cycle right after the strobe was sampled.
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_data = b;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, cfg_valid}, 0);
    chk({tag, ".ok"},    {31'd0, frame_ok}, 0);
    chk({tag, ".err"},   {31'd0, frame_err}, 0);
    chk({tag, ".code"},  {30'd0, err_code}, 0);
    chk({tag, ".cnt"},   {16'd0, frame_cnt}, 0);
    chk({tag, ".addr"},  {24'd0, cfg_addr}, 0);
    chk({tag, ".data"},  cfg_data, 0);
    chk({tag, ".txs"},   {31'd0, tx_start}, 0);
    chk({tag, ".txd"},   {24'd0, tx_data}, 0);
  endtask

  initial begin
    // Reset state
    ticks(3);
    chk_all_zero("rst");
    sys_rst_n = 1'b0;
    tick();

    // 1: good frame, cfg_ready=1
    send(8'hAA); send(8'h10); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("t1.pre_valid", {31'd0, cfg_valid}, 0);
    send(8'h24);
    chk("t1.valid", {31'd0, cfg_valid}, 1);
    chk("t1.addr", {24'd0, cfg_addr}, 32'h10);
    chk("t1.data", cfg_data, 32'h12345678);
    chk("t1.ok_early", {31'd0, frame_ok}, 0);
    tick();
    chk("t1.valid_drop", {31'd0, cfg_valid}, 0);
    chk("t1.ok", {31'd0, frame_ok}, 1);
    chk("t1.cnt", {16'd0, frame_cnt}, 1);
    tick();
    chk("t1.ok_pulse", {31'd0, frame_ok}, 0);
`ifdef UART_CFG_ACK_EN
    chk("t1.ack_start", {31'd0, tx_start}, 1);
    chk("t1.ack_data", {24'd0, tx_data}, 32'h06);
`else
    chk("t1.tx_off", {31'd0, tx_start}, 0);
`endif

    // 2: bad checksum, then good frame
    send(8'hAA); send(8'h10); send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h25);
    chk("t2.valid", {31'd0, cfg_valid}, 0);
    chk("t2.err", {31'd0, frame_err}, 1);
    chk("t2.code", {30'd0, err_code}, 1);
    tick();
    chk("t2.err_pulse", {31'd0, frame_err}, 0);
    chk("t2.code_hold", {30'd0, err_code}, 1);
`ifdef UART_CFG_ACK_EN
    chk("t2.nak_start", {31'd0, tx_start}, 1);
    chk("t2.nak_data", {24'd0, tx_data}, 32'h15);
`endif
    send(8'hAA); send(8'h20); send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h21);
    chk("t2.valid2", {31'd0, cfg_valid}, 1);
    chk("t2.addr2", {24'd0, cfg_addr}, 32'h20);
    chk("t2.data2", cfg_data, 32'h00000001);
    tick();
    chk("t2.ok2", {31'd0, frame_ok}, 1);
    chk("t2.cnt2", {16'd0, frame_cnt}, 2);
    tick();

    // 3: timeout 100 cycles after the last strobe (strobe in cycle t, error in t+100)
    send(8'hAA); send(8'h10); send(8'h12);
    ticks(98);
    chk("t3.no_err_99", {31'd0, frame_err}, 0);
    tick();
    chk("t3.err", {31'd0, frame_err}, 1);
    chk("t3.code", {30'd0, err_code}, 2);
    tick();
    chk("t3.err_pulse", {31'd0, frame_err}, 0);
    // strobe exactly in the expiry cycle wins
    send(8'hAA); send(8'h10); send(8'h12);
    ticks(98);
    send(8'h34);
    chk("t3.strobe_wins", {31'd0, frame_err}, 0);
    send(8'h56); send(8'h78); send(8'h24);
    chk("t3.valid", {31'd0, cfg_valid}, 1);
    chk("t3.data", cfg_data, 32'h12345678);
    tick();
    chk("t3.cnt", {16'd0, frame_cnt}, 3);
    tick();

    // 4: write stall with overrun
    cfg_ready = 1'b0;
    send(8'hAA); send(8'h30); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(8'h68);
    for (int i = 0; i < 50; i++) begin
      if (i == 20) begin
        send(8'h55);
        chk("t4.ovr_err", {31'd0, frame_err}, 1);
        chk("t4.ovr_code", {30'd0, err_code}, 3);
      end else begin
        tick();
      end
      chk("t4.valid_hold", {31'd0, cfg_valid}, 1);
      chk("t4.addr_hold", {24'd0, cfg_addr}, 32'h30);
      chk("t4.data_hold", cfg_data, 32'hDEADBEEF);
      chk("t4.no_ok", {31'd0, frame_ok}, 0);
    end
    cfg_ready = 1'b1;
    tick();
    chk("t4.ok", {31'd0, frame_ok}, 1);
    chk("t4.valid_drop", {31'd0, cfg_valid}, 0);
    chk("t4.cnt", {16'd0, frame_cnt}, 4);
    chk("t4.addr_keep", {24'd0, cfg_addr}, 32'h30);
    tick();

    // 5: idle noise, then reset mid-frame
    send(8'h00);
    chk("t5.n0", {31'd0, frame_err | cfg_valid}, 0);
    send(8'hFF);
    chk("t5.n1", {31'd0, frame_err | cfg_valid}, 0);
    send(8'h55);
    chk("t5.n2", {31'd0, frame_err | cfg_valid}, 0);
    ticks(150);
    chk("t5.no_timeout_idle", {31'd0, frame_err}, 0);
    send(8'hAA); send(8'h10); send(8'h12);
    sys_rst_n = 1'b1;
    #1;
    chk_all_zero("t5.async_rst");
    tick();
    sys_rst_n = 1'b0;
    tick();
    send(8'hAA); send(8'h01); send(8'h00); send(8'h00); send(8'h00); send(8'h05);
    send(8'h06);
    chk("t5.valid", {31'd0, cfg_valid}, 1);
    chk("t5.addr", {24'd0, cfg_addr}, 32'h01);
    chk("t5.data", cfg_data, 32'h00000005);
    tick();
    chk("t5.cnt", {16'd0, frame_cnt}, 1);
    tick();

    // 6: frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    tick();
    release dut.r_frame_cnt;
    tick();
    chk("t6.preset", {16'd0, frame_cnt}, 32'hFFFF);
    send(8'hAA); send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    send(8'h02);
    tick();
    chk("t6.ok", {31'd0, frame_ok}, 1);
    chk("t6.wrap", {16'd0, frame_cnt}, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cfg_ctrl.md
Name: uart_cfg_ctrl

Overview:
- Frame-level controller behind the UART receiver.
- Consumes the receiver's per-byte done strobe and assembles fixed-length configuration frames. A frame carries a register address, a 32-bit data word and a checksum.
- Issues one handshaked register write per valid frame to the DDS configuration register bank.
- Handles checksum errors, inter-byte timeout and overrun.

Parameters:
SYS_CLK_FRE, 50_000_000, system clock frequency in Hz
BPS, 9600, UART baud rate
TIMEOUT_BITS, 40, inter-byte timeout expressed in bit periods
TIMEOUT_CYC, SYS_CLK_FRE/BPS*TIMEOUT_BITS, inter-byte timeout in clocks; overridable; counter is 24 bits
HEADER, 8'hAA, frame start byte

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset; asynchronous, active-high (1 = reset)
rx_done  in  1  single-cycle byte strobe from UART receiver
rx_data  in  8  received byte, valid in the rx_done cycle
cfg_valid  out  1  register write request
cfg_ready  in  1  register bank accepts write
cfg_addr  out  8  register address
cfg_data  out  32  register data
frame_ok  out  1  one-cycle pulse: write accepted
frame_err  out  1  one-cycle pulse: frame or byte dropped
err_code  out  2  cause, valid with frame_err: 01 checksum, 10 timeout, 11 overrun
frame_cnt  out  16  count of accepted frames, wraps 16'hFFFF->0
tx_start  out  1  reply byte request (optional feature)
tx_data  out  8  reply byte (optional feature)
tx_busy  in  1  UART transmitter busy (optional feature)

Behaviour:
- Frame format, in order:
  - HEADER
  - ADDR
  - D3, D2, D1, D0 (MSB first)
  - CSUM
  - CSUM = (ADDR+D3+D2+D1+D0) mod 256.
- Reset values:
  - All outputs 0.
  - Internal accumulator, byte counter and timer 0.
  - State IDLE.
  - Reset mid-frame or mid-write discards everything immediately.
- States: IDLE, ADDR, DATA, CSUM, WRITE.
- IDLE:
  - rx_done with rx_data==HEADER -> ADDR.
  - Any other byte is silently ignored; no error.
- ADDR: on rx_done, latch the address, load the sum with the byte -> DATA, with the byte counter at 0.
- DATA:
  - Each rx_done shifts the byte into the data register and adds it to the sum.
  - After the 4th byte -> CSUM.
- CSUM: on rx_done, compare against the sum.
  - Equal -> WRITE. cfg_valid rises the next cycle, with cfg_addr/cfg_data stable.
  - Unequal -> IDLE. frame_err=1 and err_code=01 for one cycle.
- HEADER value has no special meaning inside a frame; no mid-frame resync.
- WRITE:
  - cfg_valid held, and cfg_addr/cfg_data held, until a cycle with cfg_valid&&cfg_ready.
  - The following cycle: cfg_valid=0, frame_ok=1 (one cycle), frame_cnt+1, -> IDLE.
  - No timeout in WRITE.
- Timer:
  - Cleared on every rx_done and in IDLE/WRITE.
  - Increments in ADDR/DATA/CSUM.
  - On reaching TIMEOUT_CYC-1 without a strobe: -> IDLE, frame_err=1, err_code=10.
  - A strobe in the same cycle as expiry wins: byte accepted, timer cleared.
- Overrun:
  - rx_done during WRITE drops the byte and pulses frame_err with err_code=11.
  - The pending write is unaffected and still completes.
- If overrun and write acceptance coincide, both frame_err and frame_ok pulse in their respective cycles.
- err_code holds its last value between errors; it is meaningful only when frame_err=1.
- cfg_addr/cfg_data keep the last written values while idle.

Optional Feature:
UART_CFG_ACK_EN
- Defined:
  - After frame_ok, reply 8'h06.
  - After a checksum or timeout error, reply 8'h15. Overrun produces no reply.
  - Replies are issued as a one-cycle tx_start with tx_data, when tx_busy==0.
  - While tx_busy==1 the reply is held pending (single slot). A newer reply overwrites an older pending one.
  - tx_data stays valid until the next reply.
- Undefined: tx_start=0 and tx_data=0 permanently; tx_busy ignored.

Test Plan:
1. Good frame with cfg_ready=1:
   - Stimulus: strobes AA 10 12 34 56 78 24.
   - Response: cfg_valid one cycle after the last strobe, cfg_addr=8'h10, cfg_data=32'h12345678, frame_ok next cycle, frame_cnt=1.
   - With UART_CFG_ACK_EN: tx_start with tx_data=8'h06.
2. Same frame with CSUM=25:
   - Response: no cfg_valid, frame_err with err_code=01, state IDLE.
   - A following good frame is accepted.
3. Timeout, with TIMEOUT_CYC=100:
   - Stimulus: AA 10 12, then silence.
   - Response: frame_err with err_code=10 exactly 100 cycles after the 12 strobe.
   - Repeat with a strobe at cycle 99: no error.
4. Write stall and overrun:
   - Stimulus: cfg_ready=0 for 50 cycles after a good frame; a stray rx_done during that window.
   - Response: cfg_valid/cfg_addr/cfg_data stable throughout; frame_err with err_code=11; write completes when cfg_ready=1.
5. Idle noise and reset:
   - Stimulus: 00 FF 55 in IDLE -> no outputs.
   - Stimulus: reset asserted after AA 10 12 -> all outputs 0; next frame AA 01 00 00 00 05 06 accepted with cfg_data=32'h00000005.
6. Counter wrap: force frame_cnt=16'hFFFF, then send a good frame -> frame_cnt=0.
